cache_control4way: RTL and testbench
====================================

CACHE_CONTROL4WAY -- requirements
Module: cache_control4way

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); reset_n input 1 (asynchronous, active-low; clears all state when 0).
REQ-002 SHALL have CPU-side ports: mem_read input 1 (read request); mem_write input 1 (write request); set_index input 3 (mem_address[2:0]); mem_resp output 1 (request complete).
REQ-003 SHALL have memory-side ports: pmem_read output 1; pmem_write output 1; pmem_resp input 1 (physical memory done).
REQ-004 SHALL have datapath status inputs, each 1 bit: hit0..hit3, valid0_out..valid3_out, dirty0_out..dirty3_out.
REQ-005 SHALL have datapath control outputs, each 1 bit unless stated: data0..3_writeline; tag0..3_write; valid0..3_write; valid_in; dirty0..3_write; dirty_in; wb_sel (0 = pmem_rdata, 1 = merged CPU line); adrmux_sel 3 bits (0 = CPU address, 1..4 = tag of way 0..3); evict_way 2 bits (way driven to pmem_wdata).

Function
REQ-006 SHALL implement states IDLE, WRITEBACK and ALLOCATE.
REQ-007 In IDLE with no request, all strobes SHALL be 0, adrmux_sel = 0 and evict_way = current victim.
REQ-008 Hit SHALL be any of hit0..3; with multiple hits, the lowest-numbered way SHALL win.
REQ-009 Read hit in IDLE SHALL assert mem_resp combinationally in the same cycle and update PLRU for the hit way at the edge; latency is 1 cycle.
REQ-010 Write hit in IDLE SHALL assert mem_resp, wb_sel = 1, data<w>_writeline = 1, dirty<w>_write = 1 and dirty_in = 1 for the hit way only, and SHALL update PLRU in the same cycle.
REQ-011 Victim selection SHALL pick the lowest-numbered invalid way; if all four ways are valid, it SHALL pick the PLRU victim.
REQ-012 On a miss in IDLE, the victim SHALL be latched; the next state SHALL be WRITEBACK if the victim is valid and dirty, else ALLOCATE; mem_resp SHALL stay 0.
REQ-013 WRITEBACK SHALL assert pmem_write, adrmux_sel = 1 + victim and evict_way = victim until pmem_resp, then go to ALLOCATE.
REQ-014 ALLOCATE SHALL assert pmem_read, adrmux_sel = 0 and wb_sel = 0 until pmem_resp.
REQ-015 In the pmem_resp cycle, ALLOCATE SHALL pulse data/tag/valid/dirty write for the victim with valid_in = 1 and dirty_in = 0, then return to IDLE.
REQ-016 After a refill, the request SHALL be serviced as a hit on the following IDLE cycle; miss latency is the refill path + 1 cycle.
REQ-017 PLRU SHALL be 3 bits per set (b0 root, b1 ways 0/1, b2 ways 2/3); the victim is b0 = 0 ? (b1 ? 1 : 0) : (b2 ? 3 : 2).
REQ-018 PLRU update on an access to way 0/1/2/3 SHALL write {b0,b1} = {1,1}/{1,0} and {b0,b2} = {0,1}/{0,0} respectively; other bits hold.
REQ-019 PLRU SHALL update only on hits, never on misses or refill.
REQ-020 pmem_resp in IDLE SHALL be ignored.
REQ-021 mem_read and mem_write both high SHALL be treated as a write.
REQ-022 A request dropped mid-miss SHALL not abort the miss: writeback/refill completes, then the FSM returns to IDLE with no mem_resp.
REQ-023 The latched victim and set_index SHALL be used throughout a miss; the CPU holds its address until mem_resp.

Reset
REQ-024 reset_n = 0 SHALL immediately force IDLE, deassert pmem_read, pmem_write, mem_resp and all write strobes, and clear every PLRU bit to 0 (victim way 0), including mid-WRITEBACK or mid-ALLOCATE.
REQ-025 After reset, evict_way SHALL be 0 and adrmux_sel SHALL be 0.

Structure
REQ-026 The state enum and PLRU typedef (3-bit) SHALL be added to the lc3b_types package.
REQ-027 PLRU storage plus the victim/update logic SHALL be one sub-module, cache_plru (8 x 3 bits, async reset, write on update strobe).
REQ-028 State register and next-state logic SHALL be separate; outputs SHALL be combinational from state and inputs.

Verification
REQ-029 Cold read miss, set 3, all ways invalid -> ALLOCATE, pmem_read until pmem_resp, then way 0 tag/data/valid written with dirty 0; mem_resp on the next cycle.
REQ-030 Write hit on way 2, set 5 -> same-cycle mem_resp, data2_writeline, dirty2_write with dirty_in = 1, wb_sel = 1; set 5 PLRU becomes b0 = 0, b2 = 1.
REQ-031 All 4 ways valid in set 1, accesses to ways 0, 1, 2, 3 in order, then a miss -> victim way 0.
REQ-032 Dirty victim way 1 -> WRITEBACK with adrmux_sel = 2 and evict_way = 1 until pmem_resp, then ALLOCATE with adrmux_sel = 0.
REQ-033 reset_n = 0 during ALLOCATE while pmem_read = 1 -> pmem_read = 0 without waiting for clk; state IDLE; all PLRU bits read 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the 4-way cache controller: FSM state, PLRU tree bits and
// the pure tree/priority helpers used by the controller and the PLRU store.
package lc3b_types;

    localparam int unsigned NumWays = 4;
    localparam int unsigned NumSets = 8;
    localparam int unsigned SetW    = 3;
    localparam int unsigned WayW    = 2;

    typedef logic [SetW-1:0]    set_idx_t;
    typedef logic [WayW-1:0]    way_idx_t;
    typedef logic [NumWays-1:0] way_vec_t;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StAllocate
    } cache_state_e;

    // bit 0 is the root, bit 1 covers ways 0/1, bit 2 covers ways 2/3
    typedef logic [2:0] plru_t;

    function automatic way_idx_t plru_victim(plru_t p);
        way_idx_t v;
        if (!p[0]) begin
            v = p[1] ? 2'd1 : 2'd0;
        end else begin
            v = p[2] ? 2'd3 : 2'd2;
        end
        return v;
    endfunction

    function automatic plru_t plru_touch(plru_t p, way_idx_t way);
        plru_t n;
        n = p;
        unique case (way)
            2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
            2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
            2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
            2'd3: begin n[0] = 1'b0; n[2] = 1'b0; end
        endcase
        return n;
    endfunction

    // Lowest-numbered set bit; callers only use the result when v is non-zero.
    function automatic way_idx_t first_set(way_vec_t v);
        way_idx_t idx;
        idx = '0;
        for (int i = int'(NumWays) - 1; i >= 0; i--) begin
            if (v[i]) idx = way_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_control4way_if.sv
// Bundle of CPU, physical-memory and datapath signals seen by the cache controller.
interface cache_control4way_if;
    import lc3b_types::*;

    logic       mem_read;
    logic       mem_write;
    set_idx_t   set_index;
    logic       mem_resp;

    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_resp;

    way_vec_t   hit;
    way_vec_t   valid_out;
    way_vec_t   dirty_out;

    way_vec_t   data_writeline;
    way_vec_t   tag_write;
    way_vec_t   valid_write;
    way_vec_t   dirty_write;
    logic       valid_in;
    logic       dirty_in;
    logic       wb_sel;
    logic [2:0] adrmux_sel;
    way_idx_t   evict_way;

    // Environment side: CPU, memory and datapath.
    modport master (
        output mem_read, mem_write, set_index, pmem_resp, hit, valid_out, dirty_out,
        input  mem_resp, pmem_read, pmem_write, data_writeline, tag_write, valid_write,
               dirty_write, valid_in, dirty_in, wb_sel, adrmux_sel, evict_way
    );

    // Controller side.
    modport slave (
        input  mem_read, mem_write, set_index, pmem_resp, hit, valid_out, dirty_out,
        output mem_resp, pmem_read, pmem_write, data_writeline, tag_write, valid_write,
               dirty_write, valid_in, dirty_in, wb_sel, adrmux_sel, evict_way
    );

endinterface

// File: rtl/cache_plru.sv
// Per-set tree pseudo-LRU store: 8 sets x 3 bits, touched only on hit strobes.
module cache_plru
    import lc3b_types::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  set_idx_t set_i,
    input  logic     update_i,
    input  way_idx_t way_i,
    output way_idx_t victim_o
);

    plru_t plru_q [NumSets];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumSets); i++) begin
                plru_q[i] <= '0;
            end
        end else if (update_i) begin
            plru_q[set_i] <= plru_touch(plru_q[set_i], way_i);
        end
    end

    assign victim_o = plru_victim(plru_q[set_i]);

endmodule

// File: rtl/cache_control4way.sv
// 4-way set-associative write-back cache controller: hit service, victim choice,
// writeback and refill sequencing; outputs decode combinationally from state and inputs.
module cache_control4way
    import lc3b_types::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    cache_control4way_if.slave bus
);

    cache_state_e state_q, state_d;
    way_idx_t     victim_q, victim_d;

    logic     req;
    logic     is_hit;
    logic     plru_update;
    way_idx_t hit_way;
    way_idx_t plru_way;
    way_idx_t victim_now;
    way_vec_t victim_vec;

    // Simultaneous read and write falls through as a write via mem_write below.
    assign req        = bus.mem_read | bus.mem_write;
    assign is_hit     = |bus.hit;
    assign hit_way    = first_set(bus.hit);
    assign victim_now = (&bus.valid_out) ? plru_way : first_set(~bus.valid_out);
    assign victim_vec = way_vec_t'(1'b1) << victim_q;

    cache_plru u_plru (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .set_i    (bus.set_index),
        .update_i (plru_update),
        .way_i    (hit_way),
        .victim_o (plru_way)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        unique case (state_q)
            StIdle: begin
                if (req && !is_hit) begin
                    victim_d = victim_now;
                    state_d  = (bus.valid_out[victim_now] && bus.dirty_out[victim_now]) ?
                               StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                if (bus.pmem_resp) state_d = StAllocate;
            end
            StAllocate: begin
                if (bus.pmem_resp) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Gated by rst_ni so every strobe drops the moment reset asserts.
    always_comb begin
        bus.mem_resp       = 1'b0;
        bus.pmem_read      = 1'b0;
        bus.pmem_write     = 1'b0;
        bus.data_writeline = '0;
        bus.tag_write      = '0;
        bus.valid_write    = '0;
        bus.dirty_write    = '0;
        bus.valid_in       = 1'b0;
        bus.dirty_in       = 1'b0;
        bus.wb_sel         = 1'b0;
        bus.adrmux_sel     = 3'd0;
        bus.evict_way      = victim_now;
        plru_update        = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                StIdle: begin
                    if (req && is_hit) begin
                        bus.mem_resp = 1'b1;
                        plru_update  = 1'b1;
                        if (bus.mem_write) begin
                            bus.wb_sel         = 1'b1;
                            bus.data_writeline = way_vec_t'(1'b1) << hit_way;
                            bus.dirty_write    = way_vec_t'(1'b1) << hit_way;
                            bus.dirty_in       = 1'b1;
                        end
                    end
                end
                StWriteback: begin
                    bus.pmem_write = 1'b1;
                    bus.adrmux_sel = 3'd1 + 3'(victim_q);
                    bus.evict_way  = victim_q;
                end
                StAllocate: begin
                    bus.pmem_read = 1'b1;
                    bus.evict_way = victim_q;
                    if (bus.pmem_resp) begin
                        bus.data_writeline = victim_vec;
                        bus.tag_write      = victim_vec;
                        bus.valid_write    = victim_vec;
                        bus.dirty_write    = victim_vec;
                        bus.valid_in       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control4way.sv
// Randomized bench: the bench plays CPU, memory and tag/valid/dirty arrays, and checks
// the controller against a cache model that tracks recency as "last half / last way per pair".
module tb_cache_control4way;
    import lc3b_types::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cache_control4way_if bus ();

    cache_control4way dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Reference cache contents and replacement history.
    bit       m_valid [8][4];
    bit       m_dirty [8][4];
    int       m_tag   [8][4];
    bit       m_last_left [8];
    int       m_last_in_pair [8][2];
    int       cur_tag;
    logic [3:0] hit_force;
    int       n_checks = 0;
    int       n_errors = 0;

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            bus.hit[w] = (m_valid[bus.set_index][w] && m_tag[bus.set_index][w] == cur_tag) ||
                         hit_force[w];
            bus.valid_out[w] = m_valid[bus.set_index][w];
            bus.dirty_out[w] = m_dirty[bus.set_index][w];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset_recency();
        for (int s = 0; s < 8; s++) begin
            m_last_left[s]       = 1'b0;
            m_last_in_pair[s][0] = 1;
            m_last_in_pair[s][1] = 3;
        end
    endtask

    // Evict from the half not used last, and within it the way not used last.
    function automatic int model_victim(int s);
        int pair;
        for (int w = 0; w < 4; w++) begin
            if (!m_valid[s][w]) return w;
        end
        pair = m_last_left[s] ? 1 : 0;
        return m_last_in_pair[s][pair] ^ 1;
    endfunction

    function automatic int model_hit_way(int s);
        for (int w = 0; w < 4; w++) begin
            if ((m_valid[s][w] && m_tag[s][w] == cur_tag) || hit_force[w]) return w;
        end
        return -1;
    endfunction

    task automatic model_touch(int s, int w);
        m_last_left[s] = (w < 2);
        m_last_in_pair[s][w / 2] = w;
    endtask

    task automatic do_access(input int s, input int tag, input bit rd, input bit wr,
                             input int lat, input bit drop);
        int hw;
        int v;
        bit wb;
        bus.set_index = 3'(s);
        cur_tag       = tag;
        bus.pmem_resp = 1'($urandom_range(0, 1));
        #1;
        check_eq("idle_evict", 32'(bus.evict_way), model_victim(s));
        check_eq("idle_adrmux", 32'(bus.adrmux_sel), 0);
        check_eq("idle_pmem", 32'({bus.pmem_read, bus.pmem_write, bus.mem_resp}), 0);
        bus.pmem_resp = 1'b0;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        #1;
        hw = model_hit_way(s);
        if (hw < 0) begin
            v  = model_victim(s);
            wb = m_valid[s][v] && m_dirty[s][v];
            check_eq("miss_resp", 32'(bus.mem_resp), 0);
            check_eq("miss_evict", 32'(bus.evict_way), v);
            check_eq("miss_strobes", 32'(bus.data_writeline | bus.dirty_write), 0);
            step();
            if (wb) begin
                for (int i = 0; i <= lat; i++) begin
                    bus.pmem_resp = (i == lat);
                    #1;
                    check_eq("wb_pmem_write", 32'(bus.pmem_write), 1);
                    check_eq("wb_pmem_read", 32'(bus.pmem_read), 0);
                    check_eq("wb_adrmux", 32'(bus.adrmux_sel), 1 + v);
                    check_eq("wb_evict", 32'(bus.evict_way), v);
                    check_eq("wb_strobes", 32'(bus.tag_write | bus.data_writeline), 0);
                    step();
                end
                bus.pmem_resp = 1'b0;
            end
            for (int i = 0; i <= lat; i++) begin
                if (drop && i == 0) begin
                    bus.mem_read  = 1'b0;
                    bus.mem_write = 1'b0;
                end
                bus.pmem_resp = (i == lat);
                #1;
                check_eq("al_pmem_read", 32'(bus.pmem_read), 1);
                check_eq("al_pmem_write", 32'(bus.pmem_write), 0);
                check_eq("al_adrmux", 32'(bus.adrmux_sel), 0);
                check_eq("al_wb_sel", 32'(bus.wb_sel), 0);
                check_eq("al_resp", 32'(bus.mem_resp), 0);
                if (i == lat) begin
                    check_eq("al_data_wr", 32'(bus.data_writeline), 1 << v);
                    check_eq("al_tag_wr", 32'(bus.tag_write), 1 << v);
                    check_eq("al_valid_wr", 32'(bus.valid_write), 1 << v);
                    check_eq("al_dirty_wr", 32'(bus.dirty_write), 1 << v);
                    check_eq("al_in", 32'({bus.valid_in, bus.dirty_in}), 2);
                end else begin
                    check_eq("al_wait_strobes", 32'(bus.tag_write | bus.valid_write), 0);
                end
                step();
            end
            bus.pmem_resp = 1'b0;
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_tag[s][v]   = tag;
            if (drop) begin
                #1;
                check_eq("drop_resp", 32'(bus.mem_resp), 0);
                check_eq("drop_pmem", 32'({bus.pmem_read, bus.pmem_write}), 0);
                return;
            end
            hw = model_hit_way(s);
        end
        #1;
        check_eq("hit_resp", 32'(bus.mem_resp), 1);
        check_eq("hit_pmem", 32'({bus.pmem_read, bus.pmem_write}), 0);
        check_eq("hit_tag_wr", 32'(bus.tag_write | bus.valid_write), 0);
        if (wr) begin
            check_eq("wh_wb_sel", 32'(bus.wb_sel), 1);
            check_eq("wh_data_wr", 32'(bus.data_writeline), 1 << hw);
            check_eq("wh_dirty_wr", 32'(bus.dirty_write), 1 << hw);
            check_eq("wh_dirty_in", 32'(bus.dirty_in), 1);
        end else begin
            check_eq("rh_strobes", 32'(bus.data_writeline | bus.dirty_write), 0);
        end
        step();
        model_touch(s, hw);
        if (wr) m_dirty[s][hw] = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.set_index = '0;
        bus.pmem_resp = 1'b0;
        hit_force     = '0;
        cur_tag       = -1;
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = 0;
            end
        end
        model_reset_recency();

        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_evict", 32'(bus.evict_way), 0);
        check_eq("rst_adrmux", 32'(bus.adrmux_sel), 0);
        check_eq("rst_outs", 32'({bus.mem_resp, bus.pmem_read, bus.pmem_write}), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        // Spurious memory response while idle.
        bus.pmem_resp = 1'b1;
        step();
        check_eq("idle_pmem_resp", 32'({bus.pmem_read, bus.pmem_write}), 0);
        bus.pmem_resp = 1'b0;

        // Cold read miss into set 3 lands in way 0.
        bus.set_index = 3'd3;
        #1;
        check_eq("cold_victim", 32'(bus.evict_way), 0);
        do_access(3, 7, 1'b1, 1'b0, 2, 1'b0);

        // Write hit on way 2 of set 5.
        for (int t = 20; t < 23; t++) do_access(5, t, 1'b1, 1'b0, 0, 1'b0);
        do_access(5, 22, 1'b0, 1'b1, 0, 1'b0);
        check_eq("set5_b0", 32'(dut.u_plru.plru_q[5][0]), 0);
        check_eq("set5_b2", 32'(dut.u_plru.plru_q[5][2]), 1);

        // Full set 1, touch ways 0..3 in order, then the victim is way 0.
        for (int t = 10; t < 14; t++) do_access(1, t, 1'b1, 1'b0, 1, 1'b0);
        for (int t = 10; t < 14; t++) do_access(1, t, 1'b1, 1'b0, 0, 1'b0);
        bus.set_index = 3'd1;
        #1;
        check_eq("set1_victim", 32'(bus.evict_way), 0);
        do_access(1, 14, 1'b1, 1'b0, 1, 1'b0);

        // Multiple hits: lowest forced way wins.
        hit_force = 4'b1100;
        do_access(1, 99, 1'b1, 1'b1, 0, 1'b0);
        hit_force = 4'b0000;

        // Dirty victim in way 1 of set 2 goes through writeback.
        for (int t = 30; t < 34; t++) do_access(2, t, 1'b1, 1'b0, 0, 1'b0);
        do_access(2, 31, 1'b0, 1'b1, 0, 1'b0);
        do_access(2, 30, 1'b1, 1'b0, 0, 1'b0);
        do_access(2, 32, 1'b1, 1'b0, 0, 1'b0);
        bus.set_index = 3'd2;
        #1;
        check_eq("set2_victim", 32'(bus.evict_way), 1);
        do_access(2, 35, 1'b1, 1'b0, 2, 1'b0);

        // Reset asserted mid-refill acts without a clock edge.
        bus.set_index = 3'd4;
        cur_tag       = 50;
        bus.mem_read  = 1'b1;
        step();
        #1;
        check_eq("pre_rst_pmem_read", 32'(bus.pmem_read), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("async_rst_pmem_read", 32'(bus.pmem_read), 0);
        check_eq("async_rst_strobes", 32'(bus.data_writeline | bus.tag_write), 0);
        check_eq("async_rst_state", 32'(dut.state_q), 32'(StIdle));
        for (int s = 0; s < 8; s++) begin
            check_eq("async_rst_plru", 32'(dut.u_plru.plru_q[s]), 0);
        end
        bus.mem_read = 1'b0;
        model_reset_recency();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 2));
            do_access(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                      op != 1, op != 0, int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
